instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control FSM. Owns the program counter, drives the instruction-port address of the block RAM, and latches the returned word into an instruction register (IR).
- Presents the IR to the control FSM through a valid/ready handshake.
- Applies the FSM's branch/jump redirect when the current instruction retires.
- Block RAM read is synchronous: data is valid the cycle after the address is presented.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  out  ADDR_W  instruction fetch address to block RAM.
- mem_data  in  16  block RAM read data; valid one cycle after mem_addr.
- ir  out  16  instruction register.
- ir_valid  out  1  ir holds an instruction not yet accepted.
- ir_ready  in  1  control FSM retires ir this cycle.
- pc  out  ADDR_W  address of the instruction in ir.
- pc_plus1  out  ADDR_W  pc+1 mod 2^ADDR_W, used for the link value.
- br_take  in  1  redirect on retire; sampled only when ir_valid && ir_ready.
- br_abs  in  1  1 = absolute target, 0 = PC-relative displacement.
- br_disp  in  8  signed displacement, sign-extended to ADDR_W.
- br_target  in  ADDR_W  absolute jump target (register contents).

Behaviour:
- Reset (asynchronous, any state): state=ISSUE, pc=fetch_pc=RESET_PC, ir=16'h0000, ir_valid=0. mem_addr follows fetch_pc, so it equals RESET_PC.
- States: ISSUE, CAPTURE, HOLD.
- ISSUE: mem_addr=fetch_pc; ir_valid=0; next state CAPTURE.
- CAPTURE: ir<=mem_data, pc<=fetch_pc, ir_valid<=1; next state HOLD.
- HOLD: ir, pc and ir_valid are stable. mem_addr=fetch_pc, where fetch_pc==pc.
  - On ir_valid && ir_ready: compute next_pc; fetch_pc<=next_pc; ir_valid<=0; next state ISSUE.
  - Without ir_ready: remain in HOLD and ignore every br_* input.
- next_pc rules:
  - !br_take: pc+1.
  - br_take && !br_abs: pc+1+sext(br_disp).
  - br_take && br_abs: br_target.
  - All sums are truncated to ADDR_W; wrap-around is legal, e.g. pc=16'hFFFF with no branch gives 16'h0000.
- Latency: first ir_valid=1 appears 2 rising edges after reset deasserts. With the optional feature off, sequential throughput is one instruction per 3 cycles when ir_ready is held high.
- ir_ready while ir_valid=0: ignored.
- Two-cycle instructions: the control FSM holds ir_ready=0 during its second (LOAD) cycle. ir is guaranteed stable for that cycle.
- br_disp = -1 with !br_abs: next_pc = pc, a legal self-loop.

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined:
  - In HOLD, mem_addr=pc+1, so the sequential successor is already on mem_data.
  - On ir_valid && ir_ready && !br_take: ir<=mem_data, pc<=pc+1, ir_valid stays 1, state stays HOLD. Sequential throughput becomes 1 instruction/cycle.
  - Taken branches follow the normal ISSUE/CAPTURE path (2-cycle bubble).
  - The block RAM port must not be written at pc+1 during HOLD; this is the software's responsibility.
- Undefined: behaviour exactly as described above; mem_addr=fetch_pc in all states.

Decomposition:
- Shared package/include: fetch state encodings (ISSUE=2'd0, CAPTURE=2'd1, HOLD=2'd2) and RESET_PC default, placed alongside the instruction set definitions.
- One sub-module: pc_next_calc, combinational. Inputs: pc, br_take, br_abs, br_disp, br_target. Outputs: pc_plus1, next_pc.

Test Plan:
- Reset release, RAM[0]=16'h5301, ir_ready held 0 → cycle 2: ir=16'h5301, ir_valid=1, pc=0; ir, pc and ir_valid hold indefinitely.
- Sequential run, RAM[0..3] distinct, ir_ready=1 → ir sequence RAM[0..3], pc 0,1,2,3. ir_valid pulses 1 cycle in 3 without FETCH_PREFETCH_EN; continuously 1 with it.
- pc=16'h0010, br_take=1, br_abs=0, br_disp=8'hFC → next pc=16'h000D. With br_disp=8'h7F → next pc=16'h0090.
- pc=16'h0004, br_take=1, br_abs=1, br_target=16'h0200 → next ir=RAM[16'h0200], pc=16'h0200. Case with br_take=1 but ir_ready=0 → no redirect occurs.
- ADDR_W=16, pc=16'hFFFF, no branch → next pc=16'h0000. pc=16'h0000 with br_disp=8'h80 → next pc=16'hFF81.
- Assert reset while in CAPTURE and while in HOLD → ir_valid=0 and pc=RESET_PC immediately (asynchronous); fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch path: instruction word width,
// default address width / reset PC, and the fetch sequencer state encoding.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    // Instruction set word width (every instruction is one 16-bit word).
    localparam int WORD_W = 16;

    // Fetch unit defaults.
    localparam int            DEFAULT_ADDR_W   = 16;
    localparam logic [15:0]   DEFAULT_RESET_PC = 16'h0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,  // address on the RAM port, data not back yet
        ST_CAPTURE = 2'd1,  // RAM data valid, loaded into ir at the edge
        ST_HOLD    = 2'd2   // ir presented to the control FSM
    } fetch_state_e;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the block RAM instruction port, the ir valid/ready handshake and the
// branch redirect inputs between the fetch unit and its neighbours.
//   master : the fetch unit (drives mem_addr, ir, ir_valid, pc, pc_plus1)
//   slave  : RAM + control FSM side (drives mem_data, ir_ready, br_*)
// ADDR_W must match the ADDR_W of the instr_fetch_unit it connects to.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              br_take;
    logic              br_abs;
    logic [7:0]        br_disp;
    logic [ADDR_W-1:0] br_target;

    modport master (
        output mem_addr, ir, ir_valid, pc, pc_plus1,
        input  mem_data, ir_ready, br_take, br_abs, br_disp, br_target
    );

    modport slave (
        input  mem_addr, ir, ir_valid, pc, pc_plus1,
        output mem_data, ir_ready, br_take, br_abs, br_disp, br_target
    );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// -----------------------------------------------------------------------------
// pc_next_calc
// Combinational successor-PC logic for the fetch unit.
//   pc        in  : address of the retiring instruction
//   br_take   in  : redirect requested
//   br_abs    in  : 1 = absolute target, 0 = PC-relative displacement
//   br_disp   in  : signed 8-bit displacement, relative to pc+1
//   br_target in  : absolute target
//   pc_plus1  out : pc+1 (wraps), also used as the link value
//   next_pc   out : address of the next instruction to fetch
// All sums truncate to ADDR_W, so wrap-around is intentional.
// -----------------------------------------------------------------------------
module pc_next_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              br_take,
    input  logic              br_abs,
    input  logic [7:0]        br_disp,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] disp_ext;

    assign pc_plus1 = pc + ADDR_W'(1);
    assign disp_ext = {{(ADDR_W-8){br_disp[7]}}, br_disp};

    always_comb begin
        next_pc = pc_plus1;
        if (br_take) begin
            next_pc = br_abs ? br_target : pc_plus1 + disp_ext;
        end
    end

endmodule : pc_next_calc

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter, drives the block RAM instruction address, latches
// the returned word into ir and offers it to the control FSM via valid/ready.
// A taken branch/jump is applied when the current instruction retires.
//   clk   in : system clock, rising edge
//   reset in : asynchronous, active-high reset
//   bus      : instr_fetch_unit_if.master (RAM port, ir handshake, branch in)
// Optional feature, macro FETCH_PREFETCH_EN: while holding ir, the RAM port
// already addresses the sequential successor so a non-branching retire
// reloads ir in the same cycle (one instruction per cycle). Without the macro
// each instruction costs ISSUE -> CAPTURE -> HOLD (one per three cycles).
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;
    logic              retire;
    logic              seq_stream;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
        .pc        (pc_q),
        .br_take   (bus.br_take),
        .br_abs    (bus.br_abs),
        .br_disp   (bus.br_disp),
        .br_target (bus.br_target),
        .pc_plus1  (pc_plus1),
        .next_pc   (next_pc)
    );

    // ir_ready only counts while an instruction is actually offered.
    assign retire = ir_valid_q && bus.ir_ready;

`ifdef FETCH_PREFETCH_EN
    // Non-branching retire that can be refilled straight from mem_data.
    assign seq_stream = retire && !bus.br_take;
`else
    assign seq_stream = 1'b0;
`endif

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;

        case (state_q)
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                ir_d       = bus.mem_data;
                pc_d       = fetch_pc_q;
                ir_valid_d = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (seq_stream) begin
                    ir_d       = bus.mem_data;
                    pc_d       = pc_plus1;
                    fetch_pc_d = pc_plus1;
                end else if (retire) begin
                    fetch_pc_d = next_pc;
                    ir_valid_d = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

`ifdef FETCH_PREFETCH_EN
    // The RAM answers one cycle late, so whenever the next cycle is HOLD the
    // port must already address the successor of the pc that cycle will show.
    // This gives a combinational ir_ready -> mem_addr path in this build.
    assign bus.mem_addr = (state_d == ST_HOLD) ? pc_d + ADDR_W'(1) : fetch_pc_q;
`else
    assign bus.mem_addr = fetch_pc_q;
`endif

    assign bus.ir       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.pc       = pc_q;
    assign bus.pc_plus1 = pc_plus1;

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ISSUE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

endmodule : instr_fetch_unit
